oai_activity_pipe: RTL and testbench
====================================

Name: oai_activity_pipe

Overview:
- Parametrised, registered successor to the fixed OAI222 cell: NCH independent channels, each evaluating an NGRP-group by GW-input OR-AND-INVERT function, or AND-OR-INVERT when MODE=1.
- Results pass through an STAGES-deep enable-gated pipeline.
- Each channel has a saturating output-toggle counter, used by the power-characterisation flow to measure switching activity per channel.

Parameters:
- NCH, 4: number of channels.
- NGRP, 3: groups per channel (min 2).
- GW, 2: inputs per group (min 2).
- STAGES, 1: pipeline register depth, legal 1..4.
- CNTW, 16: toggle counter width per channel.

Ports:
- CLK  input  1  clock, rising edge.
- RSTB  input  1  asynchronous active-low reset.
- EN  input  1  pipeline advance; 0 freezes all pipeline and counter state.
- MODE  input  1  0 = OAI (OR within group, NAND across groups); 1 = AOI (AND within group, NOR across groups).
- IN  input  NCH*NGRP*GW  operand bits. Channel c, group g, input i maps to IN[c*NGRP*GW + g*GW + i].
- IN_VLD  input  1  IN and MODE are valid this cycle.
- QN  output  NCH  registered result, bit c = channel c.
- QN_VLD  output  1  QN holds a valid result.
- CNT_CLR  input  1  synchronous clear of all toggle counters and saturation flags.
- TOG_CNT  output  NCH*CNTW  toggle count; channel c at [c*CNTW +: CNTW].
- CNT_SAT  output  NCH  sticky saturation flag per channel.

Behaviour:
- Async reset (RSTB=0), effective immediately, independent of CLK:
  - all pipeline data bits = 1 (the OAI result of all-zero inputs); QN = all ones
  - all pipeline valid bits = 0; QN_VLD = 0
  - TOG_CNT = 0, CNT_SAT = 0
  - last-valid-output register = all ones
- Reset deassertion mid-stream: the pipeline restarts empty. Nothing in flight before reset is ever presented.
- Evaluation per channel c:
  - OAI: QN = ~&(|group_g) over g.
  - AOI: QN = ~|(&group_g) over g.
  - MODE is sampled together with IN at stage 0 and applies only to that sample's result. It never re-evaluates data already in flight.
- Pipeline:
  - Stage 0 captures f(IN, MODE) and IN_VLD on a rising CLK edge with EN=1.
  - Stage k captures stage k-1 on edges with EN=1.
  - QN/QN_VLD are the last stage. Latency is exactly STAGES enabled edges from IN sample to QN.
  - EN=0 holds every stage, including QN_VLD. A held valid is not re-counted.
  - IN_VLD=0 with EN=1 inserts a bubble. Bubble data bits retain the previous stage-0 data, so QN does not glitch to a meaningless value.
- Toggle counting, per channel, on an enabled edge where the incoming last-stage valid is 1:
  - If new QN bit != last-valid-output bit, the counter increments by 1.
  - The last-valid-output register then updates to the new bit.
  - Bubbles neither count nor update the register.
  - The first valid result after reset or CNT_CLR is compared against the reset value 1.
- Saturation:
  - The counter stops at 2^CNTW-1; further toggles are ignored.
  - CNT_SAT sets on the edge where the counter reaches 2^CNTW-1 and stays set until CNT_CLR or reset.
- CNT_CLR:
  - Acts on the CLK edge regardless of EN.
  - Clears TOG_CNT and CNT_SAT and sets last-valid-output to all ones.
  - Has priority over a same-edge increment, which is discarded.
  - Does not affect the pipeline or QN.
- Illegal STAGES outside 1..4 or NGRP/GW < 2: elaboration error.

Decomposition:
- Shared package oai_pkg holds:
  - MODE encodings MODE_OAI=1'b0, MODE_AOI=1'b1
  - reset constant QN_RST=1'b1
  - a parameter-check function for the legal STAGES/NGRP/GW ranges
- Sub-module oai_grp_eval: one channel's combinational OAI/AOI evaluation, parameters NGRP and GW, instantiated NCH times.
- Pipeline and counters stay in the top module.

Test Plan:
Configuration for all scenarios: NCH=4, NGRP=3, GW=2, STAGES=2, CNTW=4.
- Reset: hold RSTB=0 with IN toggling -> QN=4'hF, QN_VLD=0, TOG_CNT=0, CNT_SAT=0. Release RSTB and apply IN_VLD=0 for 3 edges -> QN_VLD stays 0.
- OAI function: EN=1, MODE=0, IN_VLD=1.
  - Channel 0 IN[5:0]=6'b010101 -> QN[0]=0 exactly 2 edges later, with QN_VLD=1.
  - Next cycle IN[5:0]=6'b000101 (group 2 all zero) -> QN[0]=1. TOG_CNT ch0 = 2 (1→0, 0→1).
- AOI mode in flight: MODE=1 with channel 1 IN[11:6]=6'h3F, then MODE=0 with the same IN on the next cycle -> QN[1] = 0 then 0. A MODE toggle on the second sample does not alter the first result.
- Stall and bubble:
  - Drive a 0/1 alternating stream on channel 2, hold EN=0 for 5 cycles mid-stream -> QN and QN_VLD frozen and TOG_CNT unchanged during the stall. Counts resume correctly after EN=1.
  - An IN_VLD=0 gap produces QN_VLD=0 for exactly one cycle, with no count.
- Saturation and clear:
  - 20 alternating results on channel 3 -> TOG_CNT ch3 = 4'hF and CNT_SAT[3]=1.
  - Assert CNT_CLR on the same edge as a toggle -> TOG_CNT ch3 = 0 and CNT_SAT[3]=0 next cycle.
- Reset mid-operation: pull RSTB low between edges with a full pipeline -> QN=4'hF and QN_VLD=0 immediately, before the next CLK edge. After release, the first valid appears only 2 enabled edges after a new IN_VLD.

Source files
------------

// File: rtl/oai_pkg.sv
// rtl/oai_pkg.sv - shared encodings, reset constant and parameter check for the OAI activity pipe
package oai_pkg;

    localparam logic MODE_OAI = 1'b0;
    localparam logic MODE_AOI = 1'b1;

    // Pipeline data reset value: the OAI result of all-zero inputs.
    localparam logic QN_RST = 1'b1;

    function automatic bit params_ok(input int stages, input int ngrp, input int gw);
        return (stages >= 1) && (stages <= 4) && (ngrp >= 2) && (gw >= 2);
    endfunction

endpackage

// File: rtl/oai_grp_eval.sv
// rtl/oai_grp_eval.sv - one channel of NGRP x GW OR-AND-INVERT / AND-OR-INVERT evaluation
//
// Ports:
//   mode    - MODE_OAI: OR within group, NAND across groups; MODE_AOI: AND within group, NOR across groups
//   grp_in  - group g, input i at grp_in[g*GW + i]
//   qn      - combinational result
module oai_grp_eval
    import oai_pkg::*;
#(
    parameter int NGRP = 3,
    parameter int GW   = 2
) (
    input  logic                 mode,
    input  logic [NGRP*GW-1:0]   grp_in,
    output logic                 qn
);

    logic [NGRP-1:0] grp_or;
    logic [NGRP-1:0] grp_and;

    always_comb begin
        grp_or  = '0;
        grp_and = '0;
        for (int g = 0; g < NGRP; g++) begin
            grp_or[g]  = |grp_in[g*GW +: GW];
            grp_and[g] = &grp_in[g*GW +: GW];
        end
    end

    assign qn = (mode == MODE_AOI) ? ~|grp_and : ~&grp_or;

endmodule

// File: rtl/oai_activity_pipe.sv
// rtl/oai_activity_pipe.sv - NCH-channel registered OAI/AOI pipeline with per-channel saturating toggle counters
//
// Ports:
//   CLK, RSTB       - rising-edge clock, asynchronous active-low reset
//   EN              - advances pipeline and counters; 0 freezes them (CNT_CLR still acts)
//   MODE, IN, IN_VLD- operands sampled at stage 0; channel c group g input i at IN[c*NGRP*GW + g*GW + i]
//   QN, QN_VLD      - last pipeline stage
//   CNT_CLR         - synchronous clear of toggle counters, saturation flags and last-valid bits
//   TOG_CNT         - channel c toggle count at [c*CNTW +: CNTW]
//   CNT_SAT         - sticky per-channel saturation flag
module oai_activity_pipe
    import oai_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int NGRP   = 3,
    parameter int GW     = 2,
    parameter int STAGES = 1,
    parameter int CNTW   = 16
) (
    input  logic                 CLK,
    input  logic                 RSTB,
    input  logic                 EN,
    input  logic                 MODE,
    input  logic [NCH*NGRP*GW-1:0] IN,
    input  logic                 IN_VLD,
    output logic [NCH-1:0]       QN,
    output logic                 QN_VLD,
    input  logic                 CNT_CLR,
    output logic [NCH*CNTW-1:0]  TOG_CNT,
    output logic [NCH-1:0]       CNT_SAT
);

    if (!params_ok(STAGES, NGRP, GW)) begin : g_bad_params
        $error("oai_activity_pipe: STAGES must be 1..4 and NGRP, GW at least 2");
    end

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [NCH-1:0] f_now;

    for (genvar c = 0; c < NCH; c++) begin : g_eval
        oai_grp_eval #(
            .NGRP (NGRP),
            .GW   (GW)
        ) u_eval (
            .mode   (MODE),
            .grp_in (IN[c*NGRP*GW +: NGRP*GW]),
            .qn     (f_now[c])
        );
    end

    logic [NCH-1:0]    pipe_data [STAGES];
    logic [STAGES-1:0] pipe_vld;
    logic [NCH-1:0]    nxt_data  [STAGES];
    logic [STAGES-1:0] nxt_vld;

    // A bubble keeps the previous stage-0 data so QN never shows a meaningless value.
    always_comb begin
        nxt_vld     = '0;
        nxt_data[0] = IN_VLD ? f_now : pipe_data[0];
        nxt_vld[0]  = IN_VLD;
        for (int k = 1; k < STAGES; k++) begin
            nxt_data[k] = pipe_data[k-1];
            nxt_vld[k]  = pipe_vld[k-1];
        end
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            for (int k = 0; k < STAGES; k++) begin
                pipe_data[k] <= {NCH{QN_RST}};
            end
            pipe_vld <= '0;
        end else if (EN) begin
            for (int k = 0; k < STAGES; k++) begin
                pipe_data[k] <= nxt_data[k];
            end
            pipe_vld <= nxt_vld;
        end
    end

    assign QN     = pipe_data[STAGES-1];
    assign QN_VLD = pipe_vld[STAGES-1];

    // Counting looks at what the last stage is about to capture, so a result
    // is counted exactly once, on the edge it arrives at QN.
    logic [NCH-1:0] arr_data;
    logic           arr_vld;

    assign arr_data = nxt_data[STAGES-1];
    assign arr_vld  = EN && nxt_vld[STAGES-1];

    for (genvar c = 0; c < NCH; c++) begin : g_cnt
        logic [CNTW-1:0] cnt;
        logic            sat;
        logic            last_q;

        always_ff @(posedge CLK or negedge RSTB) begin
            if (!RSTB) begin
                cnt    <= '0;
                sat    <= 1'b0;
                last_q <= QN_RST;
            end else if (CNT_CLR) begin
                cnt    <= '0;
                sat    <= 1'b0;
                last_q <= QN_RST;
            end else if (arr_vld) begin
                if ((arr_data[c] != last_q) && (cnt != CNT_MAX)) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_MAX - 1'b1) begin
                        sat <= 1'b1;
                    end
                end
                last_q <= arr_data[c];
            end
        end

        assign TOG_CNT[c*CNTW +: CNTW] = cnt;
        assign CNT_SAT[c]              = sat;
    end

endmodule

// File: tb/tb_oai_activity_pipe.sv
// tb/tb_oai_activity_pipe.sv - self-checking bench for oai_activity_pipe (NCH=4 NGRP=3 GW=2 STAGES=2 CNTW=4)
module tb_oai_activity_pipe;

    localparam int NCH    = 4;
    localparam int NGRP   = 3;
    localparam int GW     = 2;
    localparam int STAGES = 2;
    localparam int CNTW   = 4;
    localparam int INW    = NCH*NGRP*GW;

    logic                 CLK = 1'b0;
    logic                 RSTB;
    logic                 EN;
    logic                 MODE;
    logic [INW-1:0]       IN;
    logic                 IN_VLD;
    logic [NCH-1:0]       QN;
    logic                 QN_VLD;
    logic                 CNT_CLR;
    logic [NCH*CNTW-1:0]  TOG_CNT;
    logic [NCH-1:0]       CNT_SAT;

    oai_activity_pipe #(
        .NCH    (NCH),
        .NGRP   (NGRP),
        .GW     (GW),
        .STAGES (STAGES),
        .CNTW   (CNTW)
    ) dut (
        .CLK     (CLK),
        .RSTB    (RSTB),
        .EN      (EN),
        .MODE    (MODE),
        .IN      (IN),
        .IN_VLD  (IN_VLD),
        .QN      (QN),
        .QN_VLD  (QN_VLD),
        .CNT_CLR (CNT_CLR),
        .TOG_CNT (TOG_CNT),
        .CNT_SAT (CNT_SAT)
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a window of the most recent STAGES enabled-edge samples,
    // plus per-channel counter state.
    typedef struct {
        logic           vld;
        logic [NCH-1:0] data;
    } ent_t;

    ent_t           hist[$];
    logic [NCH-1:0] stage0_prev;
    logic [NCH-1:0] m_last;
    logic [NCH-1:0] m_sat;
    int             m_cnt [NCH];

    function automatic logic [NCH-1:0] ref_f(input logic [INW-1:0] v, input logic m);
        logic [NCH-1:0] r;
        r = '0;
        for (int c = 0; c < NCH; c++) begin
            int groups_any = 0;
            int groups_all = 0;
            for (int g = 0; g < NGRP; g++) begin
                int ones = 0;
                for (int i = 0; i < GW; i++) begin
                    ones += int'(v[c*NGRP*GW + g*GW + i]);
                end
                if (ones > 0)   groups_any++;
                if (ones == GW) groups_all++;
            end
            if (!m) r[c] = !(groups_any == NGRP);
            else    r[c] = !(groups_all > 0);
        end
        return r;
    endfunction

    task automatic model_reset();
        hist.delete();
        stage0_prev = '1;
        m_last      = '1;
        m_sat       = '0;
        for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
    endtask

    task automatic model_edge(input logic en, input logic [INW-1:0] v, input logic vld,
                              input logic m, input logic clr);
        ent_t e;
        if (en) begin
            e.vld  = vld;
            e.data = vld ? ref_f(v, m) : stage0_prev;
            stage0_prev = e.data;
            hist.push_back(e);
            if (hist.size() > STAGES) void'(hist.pop_front());
        end
        if (clr) begin
            m_last = '1;
            m_sat  = '0;
            for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
        end else if (en && hist.size() == STAGES && hist[0].vld) begin
            for (int c = 0; c < NCH; c++) begin
                if (hist[0].data[c] != m_last[c] && m_cnt[c] < (1 << CNTW) - 1) begin
                    m_cnt[c]++;
                    if (m_cnt[c] == (1 << CNTW) - 1) m_sat[c] = 1'b1;
                end
                m_last[c] = hist[0].data[c];
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [NCH-1:0]      e_qn;
        logic                e_vld;
        logic [NCH*CNTW-1:0] e_cnt;
        if (hist.size() == STAGES) begin
            e_qn  = hist[0].data;
            e_vld = hist[0].vld;
        end else begin
            e_qn  = '1;
            e_vld = 1'b0;
        end
        for (int c = 0; c < NCH; c++) e_cnt[c*CNTW +: CNTW] = m_cnt[c][CNTW-1:0];
        check({tag, ".qn"},      32'(QN),      32'(e_qn));
        check({tag, ".qn_vld"},  32'(QN_VLD),  32'(e_vld));
        check({tag, ".tog_cnt"}, 32'(TOG_CNT), 32'(e_cnt));
        check({tag, ".cnt_sat"}, 32'(CNT_SAT), 32'(m_sat));
    endtask

    // Drive inputs, take one edge, advance the model (held in reset while RSTB=0), check #1 later.
    task automatic step(input logic en, input logic [INW-1:0] v, input logic vld,
                        input logic m, input logic clr, input string tag);
        EN = en; IN = v; IN_VLD = vld; MODE = m; CNT_CLR = clr;
        @(posedge CLK);
        if (RSTB) model_edge(en, v, vld, m, clr);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [INW-1:0] v;

        RSTB = 1'b0; EN = 1'b1; MODE = 1'b0; IN = '0; IN_VLD = 1'b1; CNT_CLR = 1'b0;
        model_reset();

        // Reset held with toggling inputs.
        for (int i = 0; i < 3; i++) step(1'b1, INW'($urandom), 1'b1, 1'b0, 1'b0, "reset_hold");
        check("reset_qn_const", 32'(QN), 32'hF);
        #2 RSTB = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, '0, 1'b0, 1'b0, 1'b0, "post_reset_bubble");
        check("post_reset_vld_const", 32'(QN_VLD), 32'h0);

        // OAI on channel 0.
        step(1'b1, 24'b010101, 1'b1, 1'b0, 1'b0, "oai_a");
        step(1'b1, 24'b000101, 1'b1, 1'b0, 1'b0, "oai_b");
        check("oai_a_qn0_const", 32'(QN[0]), 32'h0);
        check("oai_a_vld_const", 32'(QN_VLD), 32'h1);
        step(1'b1, '0, 1'b0, 1'b0, 1'b0, "oai_flush");
        check("oai_b_qn0_const", 32'(QN[0]), 32'h1);
        check("oai_cnt0_const", 32'(TOG_CNT[3:0]), 32'h2);

        // AOI then OAI on channel 1 with the same operands.
        step(1'b1, 24'h000FC0, 1'b1, 1'b1, 1'b0, "aoi_m1");
        step(1'b1, 24'h000FC0, 1'b1, 1'b0, 1'b0, "aoi_m0");
        check("aoi_m1_qn1_const", 32'(QN[1]), 32'h0);
        step(1'b1, '0, 1'b0, 1'b1, 1'b0, "aoi_flush");
        check("aoi_m0_qn1_const", 32'(QN[1]), 32'h0);

        // Alternating stream on channel 2 with a stall and a bubble.
        for (int i = 0; i < 4; i++) step(1'b1, (i % 2) ? 24'h03F000 : 24'h0, 1'b1, 1'b0, 1'b0, "stream");
        for (int i = 0; i < 5; i++) step(1'b0, INW'($urandom), 1'b1, 1'b0, 1'b0, "stall");
        for (int i = 0; i < 4; i++) step(1'b1, (i % 2) ? 24'h0 : 24'h03F000, 1'b1, 1'b0, 1'b0, "resume");
        step(1'b1, 24'h03F000, 1'b0, 1'b0, 1'b0, "bubble_in");
        step(1'b1, 24'h0, 1'b1, 1'b0, 1'b0, "bubble_mid");
        step(1'b1, 24'h03F000, 1'b1, 1'b0, 1'b0, "bubble_out");
        step(1'b1, 24'h0, 1'b1, 1'b0, 1'b0, "bubble_after");

        // Saturation on channel 3, then a clear on a toggling edge.
        for (int i = 0; i < 20; i++) step(1'b1, (i % 2) ? 24'h0 : 24'hFC0000, 1'b1, 1'b0, 1'b0, "sat_run");
        step(1'b1, 24'hFC0000, 1'b1, 1'b0, 1'b0, "sat_tail");
        check("sat_cnt3_const", 32'(TOG_CNT[15:12]), 32'hF);
        check("sat_flag3_const", 32'(CNT_SAT[3]), 32'h1);
        step(1'b1, 24'h0, 1'b1, 1'b0, 1'b1, "clr_on_toggle");
        check("clr_cnt3_const", 32'(TOG_CNT[15:12]), 32'h0);
        check("clr_flag3_const", 32'(CNT_SAT[3]), 32'h0);

        // Asynchronous reset with a full pipeline.
        for (int i = 0; i < 3; i++) step(1'b1, 24'h555555, 1'b1, 1'b0, 1'b0, "fill");
        RSTB = 1'b0;
        #1;
        model_reset();
        check("async_rst_qn_const", 32'(QN), 32'hF);
        check("async_rst_vld_const", 32'(QN_VLD), 32'h0);
        check_all("async_rst");
        step(1'b1, 24'h555555, 1'b1, 1'b0, 1'b0, "rst_low");
        #2 RSTB = 1'b1;
        step(1'b1, 24'h000001, 1'b1, 1'b0, 1'b0, "restart_1");
        check("restart_vld1_const", 32'(QN_VLD), 32'h0);
        step(1'b1, 24'h0, 1'b0, 1'b0, 1'b0, "restart_2");
        check("restart_vld2_const", 32'(QN_VLD), 32'h1);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            v = INW'($urandom);
            if ($urandom_range(0, 3) == 0) v = ($urandom_range(0, 1) != 0) ? '1 : '0;
            step(($urandom_range(0, 7) != 0), v, ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
